masked_store_buffer: RTL and testbench

MASKED_STORE_BUFFER -- requirements
Module: masked_store_buffer

---
 rtl/masked_store_buffer.sv | 137 +++++++++++++
 tb/tb_masked_store_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/masked_store_buffer.sv
// Circular store buffer with optional same-word coalescing into the youngest
// entry and byte-granular store-to-load forwarding from registered state.
module masked_store_buffer #(
  parameter int unsigned ENTRY_COUNT = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned COALESCE    = 1
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               enq_valid,
  output logic                               enq_ready,
  input  logic [ADDR_W-1:0]                  enq_addr,
  input  logic [DATA_W-1:0]                  enq_data,
  input  logic [DATA_W/8-1:0]                enq_be,
  output logic                               deq_valid,
  input  logic                               deq_ready,
  output logic [ADDR_W-1:0]                  deq_addr,
  output logic [DATA_W-1:0]                  deq_data,
  output logic [DATA_W/8-1:0]                deq_be,
  input  logic [ADDR_W-1:0]                  fwd_addr,
  input  logic [DATA_W/8-1:0]                fwd_be,
  output logic [DATA_W-1:0]                  fwd_data,
  output logic                               fwd_hit,
  output logic                               fwd_partial,
  input  logic                               flush,
  output logic [$clog2(ENTRY_COUNT+1)-1:0]   count,
  output logic                               full,
  output logic                               empty
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned PTR_W  = $clog2(ENTRY_COUNT);
  localparam int unsigned CNT_W  = $clog2(ENTRY_COUNT + 1);
  localparam int unsigned WORD_W = ADDR_W - OFF_W;

  logic [ENTRY_COUNT-1:0] valid_q;
  logic [WORD_W-1:0]      word_q [ENTRY_COUNT];
  logic [DATA_W-1:0]      data_q [ENTRY_COUNT];
  logic [BYTES-1:0]       be_q   [ENTRY_COUNT];
  logic [PTR_W-1:0]       head_q, tail_q;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [PTR_W-1:0]  young, idx;
  logic [WORD_W-1:0] enq_word, fwd_word;
  logic              merge, do_alloc, do_merge, deq_fire;
  logic [DATA_W-1:0] alloc_data, merge_data;
  logic [BYTES-1:0]  covered;

  assign enq_word = enq_addr[ADDR_W-1:OFF_W];
  assign fwd_word = fwd_addr[ADDR_W-1:OFF_W];

  always_comb begin
    young     = tail_q - PTR_W'(1);
    full      = (count_q == CNT_W'(ENTRY_COUNT));
    empty     = (count_q == '0);
    count     = count_q;
    // count >= 2 guarantees the youngest entry is never the head being drained
    merge     = (COALESCE != 0) && (count_q >= CNT_W'(2)) && (word_q[young] == enq_word);
    enq_ready = !full || merge;
    deq_valid = !empty;
    do_alloc  = enq_valid && enq_ready && (enq_be != '0) && !merge;
    do_merge  = enq_valid && enq_ready && (enq_be != '0) && merge;
    deq_fire  = deq_valid && deq_ready;
    count_d   = count_q + CNT_W'(do_alloc) - CNT_W'(deq_fire);
  end

  always_comb begin
    alloc_data = '0;
    merge_data = data_q[young];
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (enq_be[b]) begin
        alloc_data[8*b +: 8] = enq_data[8*b +: 8];
        merge_data[8*b +: 8] = enq_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    deq_addr = '0;
    deq_data = '0;
    deq_be   = '0;
    if (!empty) begin
      deq_addr = {word_q[head_q], {OFF_W{1'b0}}};
      deq_data = data_q[head_q];
      deq_be   = be_q[head_q];
    end
  end

  // Walk oldest to youngest so younger matching bytes override older ones.
  always_comb begin
    fwd_data = '0;
    covered  = '0;
    idx      = '0;
    for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (word_q[idx] == fwd_word)) begin
        for (int unsigned b = 0; b < BYTES; b++) begin
          if (fwd_be[b] && be_q[idx][b]) begin
            fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
            covered[b]         = 1'b1;
          end
        end
      end
    end
    fwd_hit     = (covered == fwd_be) && (fwd_be != '0);
    fwd_partial = (covered != '0) && !fwd_hit;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (deq_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (do_alloc) begin
        valid_q[tail_q] <= 1'b1;
        word_q[tail_q]  <= enq_word;
        data_q[tail_q]  <= alloc_data;
        be_q[tail_q]    <= enq_be;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (do_merge) begin
        data_q[young] <= merge_data;
        be_q[young]   <= be_q[young] | enq_be;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_masked_store_buffer.sv
// Directed self-checking bench for masked_store_buffer (default parameters).
module tb_masked_store_buffer;

  logic        clock = 1'b0;
  logic        reset_n, enq_valid, enq_ready, deq_valid, deq_ready;
  logic [31:0] enq_addr, enq_data, deq_addr, deq_data, fwd_addr, fwd_data;
  logic [3:0]  enq_be, deq_be, fwd_be;
  logic        fwd_hit, fwd_partial, flush, full, empty;
  logic [2:0]  count;
  int          tests_run = 0;
  int          tests_failed = 0;

  masked_store_buffer #(.ENTRY_COUNT(4), .ADDR_W(32), .DATA_W(32), .COALESCE(1)) dut (
    .clock(clock), .reset_n(reset_n), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_addr(enq_addr), .enq_data(enq_data), .enq_be(enq_be), .deq_valid(deq_valid),
    .deq_ready(deq_ready), .deq_addr(deq_addr), .deq_data(deq_data), .deq_be(deq_be),
    .fwd_addr(fwd_addr), .fwd_be(fwd_be), .fwd_data(fwd_data), .fwd_hit(fwd_hit),
    .fwd_partial(fwd_partial), .flush(flush), .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_be = be;
    cyc();
    enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_be = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fwd_addr = 32'h0; fwd_be = 4'hF;
    cyc(); cyc();
    tests_run++; if (enq_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_enq_ready got %b exp 1", enq_ready); end
    tests_run++; if (deq_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_deq_valid got %b exp 0", deq_valid); end
    tests_run++; if ({deq_addr, deq_data, deq_be} !== 68'h0) begin tests_failed++; $display("FAIL rst_deq_fields got %h %h %h exp 0", deq_addr, deq_data, deq_be); end
    tests_run++; if ({full, empty, count} !== 5'b01000) begin tests_failed++; $display("FAIL rst_status got full=%b empty=%b count=%0d exp 0 1 0", full, empty, count); end
    tests_run++; if ({fwd_hit, fwd_partial, fwd_data} !== 34'h0) begin tests_failed++; $display("FAIL rst_fwd got %b %b %h exp 0 0 0", fwd_hit, fwd_partial, fwd_data); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_fill_wrap();
    for (int k = 0; k < 6; k++) begin
      enq_valid = 1'b1; enq_addr = 32'h100 + 32'(4*k); enq_data = 32'hA000_0000 + 32'(k); enq_be = 4'hF;
      #1;
      tests_run++; if (enq_ready !== (k < 4)) begin tests_failed++; $display("FAIL fill_enq_ready[%0d] got %b exp %b", k, enq_ready, (k < 4)); end
      cyc();
    end
    enq_valid = 1'b0; enq_addr = '0;
    tests_run++; if ({count, full, enq_ready} !== 5'b10010) begin tests_failed++; $display("FAIL fill_full got count=%0d full=%b rdy=%b exp 4 1 0", count, full, enq_ready); end
    deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests_run++; if ({deq_addr, deq_data} !== {32'h100 + 32'(4*k), 32'hA000_0000 + 32'(k)}) begin tests_failed++; $display("FAIL drain[%0d] got %h %h exp %h %h", k, deq_addr, deq_data, 32'h100 + 32'(4*k), 32'hA000_0000 + 32'(k)); end
      cyc();
    end
    deq_ready = 1'b0;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL drain_empty got %b exp 1", empty); end
    push(32'h110, 32'hA000_0004, 4'hF);
    push(32'h114, 32'hA000_0005, 4'hF);
    tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL wrap_count got %0d exp 2", count); end
    deq_ready = 1'b1;
    tests_run++; if (deq_addr !== 32'h110) begin tests_failed++; $display("FAIL wrap_deq0 got %h exp 110", deq_addr); end
    cyc();
    tests_run++; if (deq_addr !== 32'h114) begin tests_failed++; $display("FAIL wrap_deq1 got %h exp 114", deq_addr); end
    cyc();
    deq_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    push(32'h500, 32'h1, 4'hF);
    push(32'h504, 32'h2, 4'hF);
    enq_valid = 1'b1; enq_addr = 32'h508; enq_data = 32'h3; enq_be = 4'hF; deq_ready = 1'b1;
    cyc();
    tests_run++; if ({count, deq_addr} !== {3'd2, 32'h504}) begin tests_failed++; $display("FAIL b2b_count got %0d %h exp 2 504", count, deq_addr); end
    deq_ready = 1'b0;
    push(32'h50C, 32'h4, 4'hF);
    push(32'h510, 32'h5, 4'hF);
    enq_valid = 1'b1; enq_addr = 32'h514; deq_ready = 1'b1;
    #1;
    tests_run++; if ({full, enq_ready} !== 2'b10) begin tests_failed++; $display("FAIL full_no_reuse got full=%b rdy=%b exp 1 0", full, enq_ready); end
    cyc();
    tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL full_deq_count got %0d exp 3", count); end
    deq_ready = 1'b0; enq_addr = 32'h600; enq_be = 4'h0;
    #1;
    tests_run++; if (enq_ready !== 1'b1) begin tests_failed++; $display("FAIL be0_ready got %b exp 1", enq_ready); end
    cyc();
    enq_valid = 1'b0;
    tests_run++; if ({count, deq_addr} !== {3'd3, 32'h508}) begin tests_failed++; $display("FAIL be0_nochange got %0d %h exp 3 508", count, deq_addr); end
    deq_ready = 1'b1; cyc(); cyc(); cyc(); deq_ready = 1'b0;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty got %b exp 1", empty); end
  endtask

  task automatic test_coalesce();
    push(32'h200, 32'h0000_BBAA, 4'h3);
    push(32'h300, 32'h4433_2211, 4'hF);
    push(32'h300, 32'hDDCC_0000, 4'hC);
    tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL coal_count got %0d exp 2", count); end
    tests_run++; if ({deq_addr, deq_data, deq_be} !== {32'h200, 32'h0000_BBAA, 4'h3}) begin tests_failed++; $display("FAIL coal_head got %h %h %h exp 200 0000bbaa 3", deq_addr, deq_data, deq_be); end
    deq_ready = 1'b1; cyc();
    tests_run++; if ({deq_addr, deq_data, deq_be} !== {32'h300, 32'hDDCC_2211, 4'hF}) begin tests_failed++; $display("FAIL coal_merged got %h %h %h exp 300 ddcc2211 f", deq_addr, deq_data, deq_be); end
    cyc(); deq_ready = 1'b0;
    push(32'h0, 32'h1, 4'hF); push(32'h4, 32'h2, 4'hF); push(32'h8, 32'h3, 4'hF); push(32'hC, 32'h4, 4'h1);
    enq_valid = 1'b1; enq_addr = 32'hE; enq_data = 32'h0000_EE00; enq_be = 4'h2;
    #1;
    tests_run++; if ({full, enq_ready} !== 2'b11) begin tests_failed++; $display("FAIL full_merge_ready got full=%b rdy=%b exp 1 1", full, enq_ready); end
    cyc(); enq_valid = 1'b0;
    fwd_addr = 32'hC; fwd_be = 4'h3; #1;
    tests_run++; if ({count, fwd_hit, fwd_data} !== {3'd4, 1'b1, 32'h0000_EE04}) begin tests_failed++; $display("FAIL full_merge_fwd got %0d %b %h exp 4 1 0000ee04", count, fwd_hit, fwd_data); end
    deq_ready = 1'b1; cyc(); cyc(); cyc(); cyc(); deq_ready = 1'b0;
  endtask

  task automatic test_no_head_merge();
    push(32'h300, 32'h0000_0011, 4'h1);
    push(32'h300, 32'h0000_2200, 4'h2);
    tests_run++; if ({count, deq_be, deq_data} !== {3'd2, 4'h1, 32'h11}) begin tests_failed++; $display("FAIL no_head_merge got %0d %h %h exp 2 1 11", count, deq_be, deq_data); end
    deq_ready = 1'b1; cyc(); cyc(); deq_ready = 1'b0;
  endtask

  task automatic test_forward();
    push(32'h40, 32'h1122_3344, 4'hF);
    push(32'h40, 32'h0000_00AA, 4'h1);
    fwd_addr = 32'h40; fwd_be = 4'hF; #1;
    tests_run++; if ({fwd_hit, fwd_partial, fwd_data} !== {2'b10, 32'h1122_33AA}) begin tests_failed++; $display("FAIL fwd_merge got %b %b %h exp 1 0 112233aa", fwd_hit, fwd_partial, fwd_data); end
    fwd_addr = 32'h44; #1;
    tests_run++; if ({fwd_hit, fwd_partial, fwd_data} !== 34'h0) begin tests_failed++; $display("FAIL fwd_miss got %b %b %h exp 0 0 0", fwd_hit, fwd_partial, fwd_data); end
    fwd_addr = 32'h42; fwd_be = 4'h2; #1;
    tests_run++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h0000_3300}) begin tests_failed++; $display("FAIL fwd_lowbits got %b %h exp 1 00003300", fwd_hit, fwd_data); end
    fwd_addr = 32'h40; fwd_be = 4'hF; deq_ready = 1'b1; #1;
    tests_run++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h1122_33AA}) begin tests_failed++; $display("FAIL fwd_during_deq got %b %h exp 1 112233aa", fwd_hit, fwd_data); end
    cyc();
    tests_run++; if ({fwd_hit, fwd_partial, fwd_data} !== {2'b01, 32'h0000_00AA}) begin tests_failed++; $display("FAIL fwd_after_deq got %b %b %h exp 0 1 000000aa", fwd_hit, fwd_partial, fwd_data); end
    cyc(); deq_ready = 1'b0;
    push(32'h50, 32'h0000_5566, 4'h3);
    fwd_addr = 32'h50; #1;
    tests_run++; if ({fwd_hit, fwd_partial, fwd_data} !== {2'b01, 32'h0000_5566}) begin tests_failed++; $display("FAIL fwd_partial got %b %b %h exp 0 1 00005566", fwd_hit, fwd_partial, fwd_data); end
    fwd_be = 4'h0; #1;
    tests_run++; if ({fwd_hit, fwd_partial} !== 2'b00) begin tests_failed++; $display("FAIL fwd_be0 got %b %b exp 0 0", fwd_hit, fwd_partial); end
    enq_valid = 1'b1; enq_addr = 32'h60; enq_data = 32'h7; enq_be = 4'hF; fwd_addr = 32'h60; fwd_be = 4'hF; #1;
    tests_run++; if (fwd_hit !== 1'b0) begin tests_failed++; $display("FAIL fwd_same_cycle got %b exp 0", fwd_hit); end
    cyc(); enq_valid = 1'b0;
    tests_run++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h7}) begin tests_failed++; $display("FAIL fwd_next_cycle got %b %h exp 1 7", fwd_hit, fwd_data); end
    deq_ready = 1'b1; cyc(); cyc(); deq_ready = 1'b0;
  endtask

  task automatic test_flush();
    push(32'h700, 32'h1, 4'hF); push(32'h704, 32'h2, 4'hF); push(32'h708, 32'h3, 4'hF);
    tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    flush = 1'b1; enq_valid = 1'b1; enq_addr = 32'h900; enq_be = 4'hF; deq_ready = 1'b1;
    cyc();
    flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    tests_run++; if ({count, empty, deq_valid} !== 5'b00010) begin tests_failed++; $display("FAIL flush_state got %0d %b %b exp 0 1 0", count, empty, deq_valid); end
    push(32'h700, 32'h1, 4'hF); push(32'h704, 32'h2, 4'hF); push(32'h708, 32'h3, 4'hF);
    reset_n = 1'b0; flush = 1'b1; enq_valid = 1'b1; enq_addr = 32'h900; enq_be = 4'hF; deq_ready = 1'b1;
    cyc();
    tests_run++; if ({count, empty, deq_valid, enq_ready, deq_addr} !== {3'd0, 3'b101, 32'h0}) begin tests_failed++; $display("FAIL reset_flush got %0d %b %b %b %h exp 0 1 0 1 0", count, empty, deq_valid, enq_ready, deq_addr); end
    reset_n = 1'b1; flush = 1'b0; enq_valid = 1'b0;
    cyc();
    tests_run++; if (deq_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_deq got %b exp 0", deq_valid); end
    deq_ready = 1'b0;
    push(32'hA00, 32'h9, 4'hF);
    tests_run++; if ({count, deq_valid, deq_addr} !== {3'd1, 1'b1, 32'hA00}) begin tests_failed++; $display("FAIL post_reset_enq got %0d %b %h exp 1 1 a00", count, deq_valid, deq_addr); end
  endtask

  initial begin
    reset_n = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_be = '0;
    deq_ready = 1'b0; fwd_addr = '0; fwd_be = '0; flush = 1'b0;
    test_reset();
    test_fill_wrap();
    test_back_to_back();
    test_coalesce();
    test_no_head_merge();
    test_forward();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
